aurora_link_supervisor: RTL and testbench
=========================================

AURORA_LINK_SUPERVISOR -- requirements
Module: aurora_link_supervisor

Interface
REQ-001 Parameter RESET_PULSE_CYCLE, default 16: cycles seq_reset_out is held high per reset attempt.
REQ-002 Parameter UP_TIMEOUT_CYCLE, default 200000000 (2 s @ 100 MHz): budget from reset release to channel_up.
REQ-003 Parameter DROP_DEBOUNCE_CYCLE, default 1000: consecutive channel_up-low cycles that count as a link drop.
REQ-004 Parameter MAX_RETRY, default 8, range 1..255: timeouts tolerated before declaring failure.
REQ-005 Port: init_clk  in  1  the single clock; all logic on its rising edge.
REQ-006 Port: ext_reset_in  in  1  reset; synchronous, active-high.
REQ-007 Port: seq_done  in  1  done from the downstream reset sequencer; already synchronous to init_clk.
REQ-008 Port: channel_up  in  1  Aurora channel status; already synchronous to init_clk.
REQ-009 Port: soft_reinit  in  1  single-cycle software request to restart link bring-up.
REQ-010 Port: seq_reset_out  out  1  drives the reset sequencer's reset input.
REQ-011 Port: link_ok  out  1  link up and stable.
REQ-012 Port: link_failed  out  1  retries exhausted; sticky until reinit.
REQ-013 Port: retry_count  out  8  timeouts since the last successful bring-up or reinit.
REQ-014 Port: drop_count  out  16  debounced link drops since reset; saturating.

Function
REQ-015 States SHALL be S_RESET, S_WAIT_DONE, S_WAIT_UP, S_UP, S_FAIL; one 32-bit timer SHALL be shared by all states and cleared on every state change.
REQ-016 S_RESET: timer counts 0..RESET_PULSE_CYCLE-1; at RESET_PULSE_CYCLE-1 -> S_WAIT_DONE.
REQ-017 S_WAIT_DONE: seq_done=1 -> S_WAIT_UP, with the timer not cleared; the timer runs continuously across S_WAIT_DONE and S_WAIT_UP.
REQ-018 S_WAIT_UP: channel_up=1 -> S_UP; retry_count cleared.
REQ-019 Timeout: in S_WAIT_DONE or S_WAIT_UP with timer==UP_TIMEOUT_CYCLE-1 and no exit condition, the state SHALL go to S_FAIL if retry_count==MAX_RETRY; otherwise retry_count increments and the state goes to S_RESET.
REQ-020 S_UP: timer counts consecutive channel_up=0 cycles and clears on any channel_up=1.
REQ-021 S_UP drop: at timer==DROP_DEBOUNCE_CYCLE-1 with channel_up=0 -> S_RESET; drop_count increments, saturating at 0xFFFF.
REQ-022 S_FAIL SHALL hold until soft_reinit or ext_reset_in.
REQ-023 soft_reinit=1 in any state other than S_RESET SHALL force S_RESET and clear retry_count and the timer; in S_RESET it SHALL be ignored.
REQ-024 Priority: ext_reset_in > soft_reinit > timeout/drop > normal transition.
REQ-025 channel_up=1 and timeout in the same S_WAIT_UP cycle SHALL take S_UP.
REQ-026 Outputs SHALL be registered, one cycle after state:
  - seq_reset_out = (state==S_RESET)
  - link_ok = (state==S_UP)
  - link_failed = (state==S_FAIL)
REQ-027 retry_count and drop_count SHALL be direct register outputs.

Reset
REQ-028 While ext_reset_in=1:
  - state = S_RESET, timer = 0, retry_count = 0, drop_count = 0
  - seq_reset_out = 1, link_ok = 0, link_failed = 0
REQ-029 After ext_reset_in falls, seq_reset_out SHALL stay high for exactly RESET_PULSE_CYCLE further cycles.
REQ-030 Reset mid-operation in any state SHALL take effect on the next edge; nothing survives it.

Structure
REQ-031 The state enum and default timing constants SHALL live in shared package aurora_ctrl_pkg.
REQ-032 A single sub-module, aurora_sat_counter (parameterised width, increment, clear, saturate), SHALL implement drop_count; everything else stays flat.

Verification
Bench parameters: RESET_PULSE_CYCLE=4, UP_TIMEOUT_CYCLE=50, DROP_DEBOUNCE_CYCLE=8, MAX_RETRY=2.
REQ-033 Clean bring-up: release reset; seq_done at cycle 10, channel_up at cycle 20 -> seq_reset_out high exactly 4 cycles; link_ok=1 from cycle 21 onward; retry_count=0.
REQ-034 Exhaustion: seq_done pulses, channel_up never rises -> three seq_reset_out pulses of 4 cycles each, retry_count reaches 2, then link_failed=1 and holds indefinitely.
REQ-035 Debounce: link up, then channel_up low for 7 cycles and high again -> link_ok stays 1, drop_count=0; then low for 8 cycles -> link_ok falls, seq_reset_out pulses, drop_count=1.
REQ-036 Reinit: in S_FAIL assert soft_reinit -> next cycle state S_RESET; link_failed=0 one cycle later; retry_count=0; normal bring-up succeeds.
REQ-037 Corner cases:
  - channel_up rising on the timeout cycle -> S_UP, no retry.
  - ext_reset_in pulsed in S_UP -> all counters 0, seq_reset_out=1.
  - 65536 forced drops -> drop_count=0xFFFF.

Source files
------------

// File: rtl/aurora_ctrl_pkg.sv
// aurora_ctrl_pkg: shared state encoding and default timing for the Aurora link supervisor.
package aurora_ctrl_pkg;
    typedef enum logic [2:0] {S_RESET, S_WAIT_DONE, S_WAIT_UP, S_UP, S_FAIL} state_t;
    localparam int RESET_PULSE_CYCLE_DEF   = 16;
    localparam int UP_TIMEOUT_CYCLE_DEF    = 200000000;
    localparam int DROP_DEBOUNCE_CYCLE_DEF = 1000;
    localparam int MAX_RETRY_DEF           = 8;
endpackage

// File: rtl/aurora_link_supervisor_if.sv
// aurora_link_supervisor_if: sequencer/channel status and supervisor outputs.
interface aurora_link_supervisor_if;
    logic        seq_done;
    logic        channel_up;
    logic        soft_reinit;
    logic        seq_reset_out;
    logic        link_ok;
    logic        link_failed;
    logic [7:0]  retry_count;
    logic [15:0] drop_count;
    modport master (
        input  seq_done, channel_up, soft_reinit,
        output seq_reset_out, link_ok, link_failed, retry_count, drop_count
    );
    modport slave (
        output seq_done, channel_up, soft_reinit,
        input  seq_reset_out, link_ok, link_failed, retry_count, drop_count
    );
endinterface

// File: rtl/aurora_sat_counter.sv
// aurora_sat_counter: W-bit up counter with clear that sticks at all-ones.
module aurora_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst || clr_i) cnt_q <= '0;
        else if (inc_i && !(&cnt_q)) cnt_q <= cnt_q + W'(1);
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/aurora_link_supervisor.sv
// aurora_link_supervisor: drives the reset sequencer, retries bring-up on timeout,
// and debounces channel drops.
module aurora_link_supervisor
    import aurora_ctrl_pkg::*;
#(
    parameter int RESET_PULSE_CYCLE   = RESET_PULSE_CYCLE_DEF,
    parameter int UP_TIMEOUT_CYCLE    = UP_TIMEOUT_CYCLE_DEF,
    parameter int DROP_DEBOUNCE_CYCLE = DROP_DEBOUNCE_CYCLE_DEF,
    parameter int MAX_RETRY           = MAX_RETRY_DEF
) (
    input  logic init_clk,
    input  logic ext_reset_in,
    aurora_link_supervisor_if.master bus
);
    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  retry_q, retry_d;
    logic        drop_inc;
    logic        timeout;
    logic        sro_d, ok_d, fail_d;
    logic        sro_q, ok_q, fail_q;

    assign timeout = timer_q == 32'(UP_TIMEOUT_CYCLE - 1);

    always_ff @(posedge init_clk) begin
        if (ext_reset_in) begin
            state_q <= S_RESET;
            timer_q <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
        end
    end

    // Exits are tested before the timeout so a late seq_done/channel_up still wins.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + 32'd1;
        retry_d  = retry_q;
        drop_inc = 1'b0;
        if (bus.soft_reinit && state_q != S_RESET) begin
            state_d = S_RESET;
            timer_d = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                S_RESET: begin
                    if (timer_q == 32'(RESET_PULSE_CYCLE - 1)) begin
                        state_d = S_WAIT_DONE;
                        timer_d = '0;
                    end
                end
                S_WAIT_DONE, S_WAIT_UP: begin
                    if (state_q == S_WAIT_DONE && bus.seq_done) begin
                        state_d = S_WAIT_UP;
                    end else if (state_q == S_WAIT_UP && bus.channel_up) begin
                        state_d = S_UP;
                        timer_d = '0;
                        retry_d = '0;
                    end else if (timeout) begin
                        state_d = retry_q == 8'(MAX_RETRY) ? S_FAIL : S_RESET;
                        retry_d = retry_q == 8'(MAX_RETRY) ? retry_q : retry_q + 8'd1;
                        timer_d = '0;
                    end
                end
                S_UP: begin
                    if (bus.channel_up) begin
                        timer_d = '0;
                    end else if (timer_q == 32'(DROP_DEBOUNCE_CYCLE - 1)) begin
                        state_d  = S_RESET;
                        timer_d  = '0;
                        drop_inc = 1'b1;
                    end
                end
                S_FAIL:  timer_d = '0;
                default: begin
                    state_d = S_RESET;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        sro_d  = state_q == S_RESET;
        ok_d   = state_q == S_UP;
        fail_d = state_q == S_FAIL;
    end

    always_ff @(posedge init_clk) begin
        if (ext_reset_in) begin
            sro_q  <= 1'b1;
            ok_q   <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            sro_q  <= sro_d;
            ok_q   <= ok_d;
            fail_q <= fail_d;
        end
    end

    aurora_sat_counter #(.W(16)) u_drop_cnt (
        .clk   (init_clk),
        .rst   (ext_reset_in),
        .clr_i (1'b0),
        .inc_i (drop_inc),
        .cnt_o (bus.drop_count)
    );

    assign bus.seq_reset_out = sro_q;
    assign bus.link_ok       = ok_q;
    assign bus.link_failed   = fail_q;
    assign bus.retry_count   = retry_q;
endmodule

// File: tb/tb_aurora_link_supervisor.sv
// tb_aurora_link_supervisor: directed vectors with hand-computed expectations
// (RESET_PULSE_CYCLE=4, UP_TIMEOUT_CYCLE=50, DROP_DEBOUNCE_CYCLE=8, MAX_RETRY=2).
module tb_aurora_link_supervisor;
    logic init_clk = 1'b0;
    logic ext_reset_in = 1'b1;
    logic sc_rst = 1'b1;
    logic sc_inc = 1'b0;
    logic [7:0] sc_cnt;
    int total = 0;
    int bad = 0;

    aurora_link_supervisor_if bus();

    aurora_link_supervisor #(
        .RESET_PULSE_CYCLE   (4),
        .UP_TIMEOUT_CYCLE    (50),
        .DROP_DEBOUNCE_CYCLE (8),
        .MAX_RETRY           (2)
    ) dut (
        .init_clk     (init_clk),
        .ext_reset_in (ext_reset_in),
        .bus          (bus)
    );

    // Narrow instance so saturation is reachable in a few hundred cycles.
    aurora_sat_counter #(.W(8)) u_sat (
        .clk   (init_clk),
        .rst   (sc_rst),
        .clr_i (1'b0),
        .inc_i (sc_inc),
        .cnt_o (sc_cnt)
    );

    always #5 init_clk = ~init_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge init_clk);
            #1;
        end
    endtask

    initial begin
        int sro_n, ok_n, falls, first_fail;
        logic prev;
        bus.seq_done = 1'b0;
        bus.channel_up = 1'b0;
        bus.soft_reinit = 1'b0;
        step(3);
        chk("rst_sro", bus.seq_reset_out, 1);
        chk("rst_ok", bus.link_ok, 0);
        chk("rst_fail", bus.link_failed, 0);
        chk("rst_retry", bus.retry_count, 0);
        chk("rst_drop", bus.drop_count, 0);
        ext_reset_in = 1'b0;

        sro_n = 0;
        ok_n = 0;
        for (int c = 1; c <= 30; c++) begin
            bus.seq_done = c >= 10;
            bus.channel_up = c >= 20;
            step(1);
            sro_n += int'(bus.seq_reset_out);
            if (c == 20) chk("up_ok_c20", bus.link_ok, 0);
            if (c >= 21) ok_n += int'(bus.link_ok);
        end
        chk("up_sro_len", sro_n, 4);
        chk("up_ok_len", ok_n, 10);
        chk("up_retry", bus.retry_count, 0);

        ok_n = 0;
        bus.channel_up = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) bus.channel_up = 1'b1;
            step(1);
            ok_n += int'(bus.link_ok);
        end
        chk("deb7_ok", ok_n, 8);
        chk("deb7_drop", bus.drop_count, 0);
        bus.channel_up = 1'b0;
        step(7);
        chk("deb8_pre_drop", bus.drop_count, 0);
        step(1);
        chk("deb8_drop", bus.drop_count, 1);
        chk("deb8_ok_lag", bus.link_ok, 1);
        step(1);
        chk("deb8_ok_fall", bus.link_ok, 0);
        chk("deb8_sro", bus.seq_reset_out, 1);

        bus.channel_up = 1'b1;
        step(10);
        chk("reup_ok", bus.link_ok, 1);
        ext_reset_in = 1'b1;
        step(1);
        chk("xrst_drop", bus.drop_count, 0);
        chk("xrst_retry", bus.retry_count, 0);
        chk("xrst_sro", bus.seq_reset_out, 1);
        chk("xrst_ok", bus.link_ok, 0);

        ext_reset_in = 1'b0;
        bus.seq_done = 1'b1;
        bus.channel_up = 1'b0;
        sro_n = 0;
        falls = 0;
        first_fail = 0;
        prev = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            step(1);
            sro_n += int'(bus.seq_reset_out);
            if (prev && !bus.seq_reset_out) falls++;
            prev = bus.seq_reset_out;
            if (bus.link_failed && first_fail == 0) first_fail = c;
        end
        chk("exh_pulses", falls, 3);
        chk("exh_sro_len", sro_n, 12);
        chk("exh_fail_at", first_fail, 163);
        chk("exh_retry", bus.retry_count, 2);
        step(200);
        chk("exh_fail_hold", bus.link_failed, 1);

        bus.soft_reinit = 1'b1;
        step(1);
        bus.soft_reinit = 1'b0;
        chk("reinit_fail_lag", bus.link_failed, 1);
        chk("reinit_retry", bus.retry_count, 0);
        step(1);
        chk("reinit_fail_clr", bus.link_failed, 0);
        chk("reinit_sro", bus.seq_reset_out, 1);
        bus.channel_up = 1'b1;
        step(10);
        chk("reinit_up", bus.link_ok, 1);

        ext_reset_in = 1'b1;
        bus.channel_up = 1'b0;
        step(1);
        ext_reset_in = 1'b0;
        step(53);
        chk("to_pre_ok", bus.link_ok, 0);
        bus.channel_up = 1'b1;
        step(1);
        chk("to_retry", bus.retry_count, 0);
        chk("to_sro", bus.seq_reset_out, 0);
        step(1);
        chk("to_up", bus.link_ok, 1);

        ext_reset_in = 1'b1;
        bus.seq_done = 1'b0;
        bus.channel_up = 1'b0;
        step(1);
        ext_reset_in = 1'b0;
        sro_n = 0;
        for (int c = 1; c <= 10; c++) begin
            bus.soft_reinit = c == 2;
            step(1);
            sro_n += int'(bus.seq_reset_out);
        end
        bus.soft_reinit = 1'b0;
        chk("reinit_in_reset", sro_n, 4);

        sc_rst = 1'b0;
        sc_inc = 1'b1;
        step(254);
        chk("sat_mid", sc_cnt, 254);
        step(1);
        chk("sat_top", sc_cnt, 255);
        step(50);
        chk("sat_hold", sc_cnt, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
